// File: rtl/unpacker32to8_pkg.sv
// Shared width constants and FSM encoding for the word-to-byte unpacker;
// the capture-side packer uses the same width constants.
package unpacker32to8_pkg;

  localparam int DATA_LEN_DEF = 32;
  localparam int LVDS_LEN_DEF = 8;
  localparam int BYTES        = DATA_LEN_DEF / LVDS_LEN_DEF;
  localparam int IDX_W        = (BYTES > 1) ? $clog2(BYTES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } state_t;

endpackage

// File: rtl/unpacker32to8.sv
// Pops DATA_LEN-bit words from a 1-cycle-latency FIFO and streams them out as
// LVDS_LEN-bit bytes over valid/ready. Define UNPACK_MSB_FIRST_EN for MSB-first order.
module unpacker32to8
  import unpacker32to8_pkg::*;
#(
  parameter int DATA_LEN = DATA_LEN_DEF,
  parameter int LVDS_LEN = LVDS_LEN_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                fifo_empty_i,
  output logic                fifo_rd_en_o,
  input  logic [DATA_LEN-1:0] fifo_data_i,
  output logic                valid_o,
  input  logic                ready_i,
  output logic [LVDS_LEN-1:0] data_o,
  output logic                last_o,
  output logic                busy_o
);

  localparam int N_BYTES = DATA_LEN / LVDS_LEN;
  localparam int IW      = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N_BYTES - 1);

  state_t                             state_q, state_d;
  logic [N_BYTES-1:0][LVDS_LEN-1:0]   word_q, word_d;
  logic [IW-1:0]                      byte_idx_q, byte_idx_d;
  logic                               rd_en_c;
  logic [IW-1:0]                      sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      word_q     <= '0;
      byte_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      byte_idx_q <= byte_idx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    byte_idx_d = byte_idx_q;
    rd_en_c    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty_i) begin
          rd_en_c = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        word_d     = fifo_data_i;
        byte_idx_d = '0;
        state_d    = SEND;
      end
      SEND: begin
        if (ready_i) begin
          if (byte_idx_q != LAST_IDX) begin
            byte_idx_d = byte_idx_q + 1'b1;
          end else if (!fifo_empty_i) begin
            // Chain straight into the next word: one LOAD bubble per word.
            rd_en_c = 1'b1;
            state_d = LOAD;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef UNPACK_MSB_FIRST_EN
  assign sel = LAST_IDX - byte_idx_q;
`else
  assign sel = byte_idx_q;
`endif

  // Gate with rst_n so a non-empty FIFO is never popped while reset is held.
  assign fifo_rd_en_o = rd_en_c & rst_n;
  assign valid_o      = (state_q == SEND);
  assign last_o       = (state_q == SEND) && (byte_idx_q == LAST_IDX);
  assign busy_o       = (state_q != IDLE);
  assign data_o       = word_q[sel];

endmodule

// File: tb/tb_unpacker32to8.sv
// Scoreboard bench for unpacker32to8: directed words through a modelled FIFO,
// expected bytes queued at issue time and checked by an independent monitor.
module tb_unpacker32to8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fifo_empty_i;
  logic        fifo_rd_en_o;
  logic [31:0] fifo_data_i;
  logic        valid_o;
  logic        ready_i;
  logic [7:0]  data_o;
  logic        last_o;
  logic        busy_o;

  unpacker32to8 dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fifo_empty_i (fifo_empty_i),
    .fifo_rd_en_o (fifo_rd_en_o),
    .fifo_data_i  (fifo_data_i),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .data_o       (data_o),
    .last_o       (last_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] fq[$];
  logic [8:0]  exp_q[$];

  int rd_cnt, vld_cnt, cyc_n, first_vld, last_vld;
  int rd_cycles[$];
  logic s_rd, s_vld;
  logic [7:0] s_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input logic [31:0] w, input int k);
`ifdef UNPACK_MSB_FIRST_EN
    return w[(3-k)*8 +: 8];
`else
    return w[k*8 +: 8];
`endif
  endfunction

  task automatic expect_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) exp_q.push_back({(k == 3), exp_byte(w, k)});
  endtask

  task automatic push_fifo(input logic [31:0] w);
    fq.push_back(w);
    fifo_empty_i = 1'b0;
  endtask

  task automatic reset_stats();
    rd_cnt = 0; vld_cnt = 0; cyc_n = 0; first_vld = -1; last_vld = -1;
    rd_cycles.delete();
  endtask

  // One clock: sample at negedge, then serve a FIFO read just after posedge.
  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      s_rd = fifo_rd_en_o; s_vld = valid_o; s_data = data_o;
      if (s_rd) begin rd_cnt++; rd_cycles.push_back(cyc_n); end
      if (s_vld) begin
        vld_cnt++;
        if (first_vld < 0) first_vld = cyc_n;
        last_vld = cyc_n;
      end
      cyc_n++;
      @(posedge clk); #1;
      if (s_rd && fq.size() > 0) begin
        fifo_data_i  = fq.pop_front();
        fifo_empty_i = (fq.size() == 0);
      end
    end
  endtask

  // Monitor: pops the scoreboard on every handshake and checks stall stability.
  logic       p_vld, p_rdy, p_last, p_rst;
  logic [7:0] p_data;
  logic [8:0] e;
  initial begin
    p_vld = 0; p_rdy = 0; p_last = 0; p_data = 0; p_rst = 0;
    forever begin
      @(negedge clk);
      if (fifo_rd_en_o && fifo_empty_i) chk("rd_en_while_empty", 32'(fifo_rd_en_o), 32'd0);
      if (p_rst && rst_n && p_vld && !p_rdy) begin
        chk("stall_valid", 32'(valid_o), 32'd1);
        chk("stall_data", 32'(data_o), 32'(p_data));
        chk("stall_last", 32'(last_o), 32'(p_last));
      end
      if (valid_o && ready_i) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL byte_unexpected: got %0h expected none", data_o);
        end else begin
          e = exp_q.pop_front();
          chk("byte_data", 32'(data_o), 32'(e[7:0]));
          chk("byte_last", 32'(last_o), 32'(e[8]));
        end
      end
      p_vld = valid_o; p_rdy = ready_i; p_data = data_o; p_last = last_o; p_rst = rst_n;
    end
  end

  logic [31:0] pat;
  int guard;

  initial begin
    rst_n = 0; ready_i = 1; fifo_empty_i = 1; fifo_data_i = '0;
    reset_stats();
    cyc(2);
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_data", 32'(data_o), 32'd0);
    chk("rst_last", 32'(last_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_rd_en", 32'(fifo_rd_en_o), 32'd0);
    rst_n = 1;

    // Empty FIFO for 20 cycles
    reset_stats();
    cyc(20);
    chk("empty_rd_cnt", rd_cnt, 0);
    chk("empty_vld_cnt", vld_cnt, 0);

    // Single word
    reset_stats();
    push_fifo(32'hA1B2C3D4); expect_word(32'hA1B2C3D4);
    cyc(10);
    chk("one_rd_cnt", rd_cnt, 1);
    if (rd_cycles.size() > 0) chk("one_latency", first_vld - rd_cycles[0], 2);
    chk("one_vld_cnt", vld_cnt, 4);
    chk("one_busy", 32'(busy_o), 32'd0);
    chk("one_sb_empty", exp_q.size(), 0);

    // Two words back-to-back
    reset_stats();
    push_fifo(32'h03020100); expect_word(32'h03020100);
    push_fifo(32'h07060504); expect_word(32'h07060504);
    cyc(14);
    chk("two_rd_cnt", rd_cnt, 2);
    if (rd_cycles.size() == 2) begin
      chk("two_rd_spacing", rd_cycles[1] - rd_cycles[0], 5);
      chk("two_span", last_vld - rd_cycles[0], 10);
    end
    chk("two_vld_cnt", vld_cnt, 8);
    chk("two_sb_empty", exp_q.size(), 0);

    // Backpressure while byte 1 is presented
    reset_stats();
    push_fifo(32'hA1B2C3D4); expect_word(32'hA1B2C3D4);
    guard = 0;
    do begin cyc(1); guard++; end
    while (!(s_vld && s_data == exp_byte(32'hA1B2C3D4, 0)) && guard < 12);
    chk("bp_reach_byte0", guard < 12, 1);
    ready_i = 0;
    reset_stats();
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      chk("bp_hold_valid", 32'(s_vld), 32'd1);
      chk("bp_hold_data", 32'(s_data), 32'(exp_byte(32'hA1B2C3D4, 1)));
    end
    chk("bp_no_rd", rd_cnt, 0);
    ready_i = 1;
    cyc(6);
    chk("bp_sb_empty", exp_q.size(), 0);
    chk("bp_busy", 32'(busy_o), 32'd0);

    // Reset after the 2nd byte of a word
    reset_stats();
    push_fifo(32'h11223344); push_fifo(32'h55667788);
    exp_q.push_back({1'b0, exp_byte(32'h11223344, 0)});
    exp_q.push_back({1'b0, exp_byte(32'h11223344, 1)});
    guard = 0;
    do begin cyc(1); guard++; end
    while (!(s_vld && s_data == exp_byte(32'h11223344, 1)) && guard < 12);
    chk("mr_reach_byte1", guard < 12, 1);
    rst_n = 0;
    #1;
    chk("mr_valid", 32'(valid_o), 32'd0);
    chk("mr_data", 32'(data_o), 32'd0);
    chk("mr_last", 32'(last_o), 32'd0);
    chk("mr_busy", 32'(busy_o), 32'd0);
    chk("mr_rd_en", 32'(fifo_rd_en_o), 32'd0);
    cyc(2);
    chk("mr_sb_empty", exp_q.size(), 0);
    reset_stats();
    expect_word(32'h55667788);
    rst_n = 1;
    cyc(10);
    chk("mr_rd_cnt", rd_cnt, 1);
    chk("mr_fifo_drained", fq.size(), 0);
    chk("mr_after_sb_empty", exp_q.size(), 0);

    // Three words under a fixed ready pattern
    reset_stats();
    push_fifo(32'hDEADBEEF); expect_word(32'hDEADBEEF);
    push_fifo(32'h0F1E2D3C); expect_word(32'h0F1E2D3C);
    push_fifo(32'h80FF007F); expect_word(32'h80FF007F);
    pat = 32'b1011_0011_1000_1101_1110_0101_1001_0111;
    for (int i = 0; i < 32; i++) begin
      ready_i = pat[i];
      cyc(1);
    end
    ready_i = 1;
    cyc(16);
    chk("pat_rd_cnt", rd_cnt, 3);
    chk("pat_sb_empty", exp_q.size(), 0);
    chk("pat_busy", 32'(busy_o), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/unpacker32to8.md
Name: unpacker32to8

Overview:
- Reverse of the capture-side byte packer: pops 32-bit words from a first-word-fall-through-less FIFO (1-cycle read latency) and serialises each word into four 8-bit bytes.
- Output uses a valid/ready handshake toward the LVDS/UART-style byte transmitter.
- Sits between the host-to-FPGA command/data FIFO and the byte-wide link.
- Default byte order is LSB-first, so packer → FIFO → unpacker is an identity on the byte stream.

Parameters:
- DATA_LEN, 32, FIFO word width; must be an integer multiple of LVDS_LEN.
- LVDS_LEN, 8, output byte width.
- BYTES (localparam), DATA_LEN/LVDS_LEN = 4, bytes per word; index width is clog2(BYTES).

Ports:
- clk  in  1  single clock domain.
- rst_n  in  1  asynchronous active-low reset.
- fifo_empty_i  in  1  source FIFO empty flag.
- fifo_rd_en_o  out  1  FIFO read strobe; data valid on fifo_data_i the following cycle.
- fifo_data_i  in  DATA_LEN  FIFO read data.
- valid_o  out  1  byte available on data_o.
- ready_i  in  1  downstream accepts the byte when valid_o && ready_i.
- data_o  out  LVDS_LEN  current byte.
- last_o  out  1  high with valid_o on the final byte of a word.
- busy_o  out  1  high whenever state != IDLE.

Behaviour:
- Reset (async assert, sync-to-clk deassert handled upstream): state=IDLE, word_q=0, byte_idx=0. Outputs: valid_o=0, data_o=0, last_o=0, busy_o=0, fifo_rd_en_o=0.
- States:
  - IDLE: fifo_rd_en_o = !fifo_empty_i; if asserted → LOAD.
  - LOAD: capture fifo_data_i into word_q, byte_idx<=0 → SEND. valid_o=0.
  - SEND: valid_o=1; data_o = word_q[byte_idx*LVDS_LEN +: LVDS_LEN]; last_o = (byte_idx==BYTES-1).
    - On handshake with byte_idx<BYTES-1: byte_idx++, stay in SEND.
    - On handshake with byte_idx==BYTES-1 and !fifo_empty_i: fifo_rd_en_o=1 in the same cycle → LOAD.
    - On handshake with byte_idx==BYTES-1 and fifo_empty_i: → IDLE.
- fifo_rd_en_o is combinational from state, byte_idx, ready_i and fifo_empty_i. It is never asserted while fifo_empty_i=1, and never asserted in LOAD.
- Handshake rules:
  - data_o and last_o stay stable while valid_o=1 and ready_i=0.
  - valid_o does not depend combinationally on ready_i.
  - ready_i is ignored outside SEND.
- Latency: first byte valid 2 cycles after IDLE sees !fifo_empty_i (rd_en cycle, then LOAD cycle).
- Sustained throughput with ready_i=1: 4 bytes per 5 cycles (one LOAD bubble per word).
- Boundaries:
  - FIFO goes empty mid-word: no effect; the current word finishes.
  - ready_i held low indefinitely: the block holds the current byte; no FIFO reads occur.
  - Reset mid-word: remaining bytes and any word in flight are discarded; the FIFO is not re-read.
- Outside SEND, data_o holds the last driven value (word_q slice); consumers must qualify with valid_o.

Optional Feature:
- UNPACK_MSB_FIRST_EN defined: byte order is reversed; byte k = word_q[(BYTES-1-k)*LVDS_LEN +: LVDS_LEN], so the MSB is sent first.
- Undefined (default): LSB-first, byte k = word_q[k*LVDS_LEN +: LVDS_LEN].
- Handshake, timing and last_o behaviour are identical in both builds.

Decomposition:
- Shared package: DATA_LEN/LVDS_LEN defaults, BYTES, index width, and the state encoding (IDLE=2'd0, LOAD=2'd1, SEND=2'd2). The packer already uses the same width constants.
- No sub-module: the byte-select mux is a single indexed part-select. The block is one module.

Test Plan:
- FIFO holds 0xA1B2C3D4, ready_i=1 → bytes D4,C3,B2,A1 on consecutive cycles; last_o only with A1; exactly one rd_en pulse; then IDLE with busy_o=0.
- Two words 0x03020100, 0x07060504 back-to-back, ready_i=1 → bytes 00..07 over 10 cycles from the first rd_en. rd_en coincides with the handshake of byte 03, with one LOAD bubble between the words.
- Backpressure: ready_i low for 3 cycles while byte 0xC3 is presented → data_o=0xC3 and valid_o=1 held stable, no rd_en, byte index unchanged; the sequence resumes correctly.
- fifo_empty_i=1 for 20 cycles → fifo_rd_en_o never asserted, valid_o=0.
- rst_n pulsed low after the 2nd byte of 0x11223344 → all outputs return to reset values immediately; after release, the next FIFO word 0x55667788 is sent from byte 0x88.
- Build with UNPACK_MSB_FIRST_EN, word 0xA1B2C3D4 → bytes A1,B2,C3,D4. Without the macro, loopback of random bytes packer8to32 → FIFO → unpacker reproduces the input stream.
